// File: rtl/partial_sched_v.sv
// partial_sched_v
// Per-sample scheduler for the additive synth partial datapath. On each
// enabled sample strobe it issues partial indices 0..NUM_PARTIALS-1 to the
// shared sine-lookup/gain pipeline, sums the in-order results into a signed
// accumulator, and publishes one saturated mixed sample.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                allows new samples to start
//   sampstart_i             one-cycle sample strobe
//   req_valid_o/req_ready_i request handshake to the partial pipeline
//   req_idx_o               partial index carried by the request
//   result_valid_i/result_i in-order pipeline results (signed)
//   sample_o/sample_valid_o last mixed sample and its one-cycle update pulse
//   busy_o                  high while a sample is in progress (RUN/DONE)
//   overrun_o               sticky: strobe arrived while a sample was active
//   protocol_err_o          sticky: result arrived that was never requested
//   clr_flags_i             clears both sticky flags (a coincident set wins)
//
// Handshake: a request transfers on a cycle where req_valid_o && req_ready_i.
// Once req_valid_o is high, it and req_idx_o stay stable until that transfer.
module partial_sched_v #(
   parameter int NUM_PARTIALS = 64,
   parameter int IDX_BITS     = 6,
   parameter int SAMP_BITS    = 16,
   parameter int ACC_BITS     = 24,
   parameter int MAX_OUT      = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic                 sampstart_i,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [IDX_BITS-1:0]  req_idx_o,
   input  logic                 result_valid_i,
   input  logic [SAMP_BITS-1:0] result_i,
   output logic [SAMP_BITS-1:0] sample_o,
   output logic                 sample_valid_o,
   output logic                 busy_o,
   output logic                 overrun_o,
   output logic                 protocol_err_o,
   input  logic                 clr_flags_i
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   // Counters need one extra bit so they can hold NUM_PARTIALS itself.
   localparam int CNT_W = IDX_BITS + 1;
   localparam int OUT_W = 4;

   localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((1 <<< (SAMP_BITS - 1)) - 1);
   localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]            resp_cnt_q, resp_cnt_d;
   logic [OUT_W-1:0]            outst_q, outst_d;
   logic signed [ACC_BITS-1:0]  acc_q, acc_d;
   logic [SAMP_BITS-1:0]        sample_q, sample_d;
   logic                        overrun_q, overrun_d;
   logic                        perr_q, perr_d;

   logic                        start;
   logic                        accept;
   logic                        res_ok;
   logic                        res_bad;
   logic signed [ACC_BITS-1:0]  result_ext;

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         issue_cnt_q <= '0;
         resp_cnt_q  <= '0;
         outst_q     <= '0;
         acc_q       <= '0;
         sample_q    <= '0;
         overrun_q   <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         resp_cnt_q  <= resp_cnt_d;
         outst_q     <= outst_d;
         acc_q       <= acc_d;
         sample_q    <= sample_d;
         overrun_q   <= overrun_d;
         perr_q      <= perr_d;
      end
   end

   assign start = (state_q == S_IDLE) && sampstart_i && enable_i;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         // Leave RUN the cycle after the final result has been counted.
         S_RUN:  if (resp_cnt_q == CNT_W'(NUM_PARTIALS)) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_valid_o    = (state_q == S_RUN) &&
                       (issue_cnt_q < CNT_W'(NUM_PARTIALS)) &&
                       (outst_q < OUT_W'(MAX_OUT));
      req_idx_o      = issue_cnt_q[IDX_BITS-1:0];
      sample_valid_o = (state_q == S_DONE);
      busy_o         = (state_q != S_IDLE);
      sample_o       = sample_q;
      overrun_o      = overrun_q;
      protocol_err_o = perr_q;
   end

   // Datapath: counters, accumulator, saturation and sticky flags
   always_comb begin
      accept      = req_valid_o && req_ready_i;
      res_ok      = (state_q == S_RUN) && result_valid_i && (outst_q != '0);
      res_bad     = result_valid_i && !res_ok;
      result_ext  = {{(ACC_BITS - SAMP_BITS){result_i[SAMP_BITS-1]}}, result_i};

      issue_cnt_d = issue_cnt_q;
      resp_cnt_d  = resp_cnt_q;
      outst_d     = outst_q;
      acc_d       = acc_q;
      sample_d    = sample_q;
      overrun_d   = overrun_q;
      perr_d      = perr_q;

      if (start) begin
         issue_cnt_d = '0;
         resp_cnt_d  = '0;
         outst_d     = '0;
         acc_d       = '0;
      end else if (state_q == S_RUN) begin
         issue_cnt_d = issue_cnt_q + CNT_W'(accept);
         resp_cnt_d  = resp_cnt_q + CNT_W'(res_ok);
         // Accept and result in the same cycle cancel out.
         outst_d     = outst_q + OUT_W'(accept) - OUT_W'(res_ok);
         if (res_ok) acc_d = acc_q + result_ext;
      end

      // Capture the mix on entry to DONE so sample_o is valid with the pulse.
      if ((state_q == S_RUN) && (state_d == S_DONE)) begin
         if (acc_q > SAT_MAX)      sample_d = SAT_MAX[SAMP_BITS-1:0];
         else if (acc_q < SAT_MIN) sample_d = SAT_MIN[SAMP_BITS-1:0];
         else                      sample_d = acc_q[SAMP_BITS-1:0];
      end

      // Clear first so a coincident setting event wins.
      if (clr_flags_i) begin
         overrun_d = 1'b0;
         perr_d    = 1'b0;
      end
      if (sampstart_i && (state_q != S_IDLE)) overrun_d = 1'b1;
      if (res_bad) perr_d = 1'b1;
   end

endmodule
